// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: writes producer words into PINGPONG_RAM in fixed-length frames
// (port A) and streams full banks out to the SPI transmitter (port B).
// Ports: s_valid/s_data/s_ready   producer word stream in
//        ram_addra/wea/dina/finisha/readya   RAM write port + bank handover
//        ram_addrb/finishb/doutb/readyb      RAM read port + bank release
//        m_valid/m_data/m_last/m_ready       word stream to SPI
//        wr_frames/rd_frames                 committed/released frame counters
module pingpong_ctrl #(
    parameter int DW        = 16,
    parameter int AW        = 7,
    parameter int FRAME_LEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic [AW-1:0] ram_addra,
    output logic          ram_wea,
    output logic [DW-1:0] ram_dina,
    output logic          ram_finisha,
    input  logic          ram_readya,
    output logic [AW-1:0] ram_addrb,
    output logic          ram_finishb,
    input  logic [DW-1:0] ram_doutb,
    input  logic          ram_readyb,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic [15:0]   wr_frames,
    output logic [15:0]   rd_frames
);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_FIN, W_SETTLE} wstate_t;
    typedef enum logic [2:0] {
        R_IDLE, R_ADDR, R_DATA, R_HOLD, R_FIN, R_SETTLE
    } rstate_t;

    // ---------------- write side ----------------
    wstate_t       w_state, w_state_d;
    logic [AW-1:0] wptr, wptr_d;
    logic          s_ready_d, wea_d, finisha_d;
    logic [AW-1:0] addra_d;
    logic [DW-1:0] dina_d;
    logic [15:0]   wr_frames_d;

    always_comb begin
        w_state_d   = w_state;
        wptr_d      = wptr;
        s_ready_d   = s_ready;
        wea_d       = 1'b0;
        addra_d     = ram_addra;
        dina_d      = ram_dina;
        finisha_d   = 1'b0;
        wr_frames_d = wr_frames;
        unique case (w_state)
            W_IDLE: begin
                if (ram_readya) begin
                    s_ready_d = 1'b1;
                    w_state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (s_valid && s_ready) begin
                    wea_d   = 1'b1;
                    addra_d = wptr;
                    dina_d  = s_data;
                    if (wptr == LAST) begin
                        s_ready_d = 1'b0;
                        w_state_d = W_FIN;
                    end else begin
                        wptr_d = wptr + AW'(1);
                    end
                end
            end
            // The last write is on the RAM port during this state, so the
            // handover pulse is raised only once that write has retired.
            W_FIN: begin
                finisha_d   = 1'b1;
                wr_frames_d = wr_frames + 16'd1;
                wptr_d      = '0;
                w_state_d   = W_SETTLE;
            end
            // ram_readya may still reflect the old bank while it swaps.
            W_SETTLE: w_state_d = W_IDLE;
            default:  w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state     <= W_IDLE;
            wptr        <= '0;
            s_ready     <= 1'b0;
            ram_wea     <= 1'b0;
            ram_addra   <= '0;
            ram_dina    <= '0;
            ram_finisha <= 1'b0;
            wr_frames   <= '0;
        end else begin
            w_state     <= w_state_d;
            wptr        <= wptr_d;
            s_ready     <= s_ready_d;
            ram_wea     <= wea_d;
            ram_addra   <= addra_d;
            ram_dina    <= dina_d;
            ram_finisha <= finisha_d;
            wr_frames   <= wr_frames_d;
        end
    end

    // ---------------- read side ----------------
    rstate_t       r_state, r_state_d;
    logic [AW-1:0] rptr, rptr_d;
    logic          m_valid_d, m_last_d, finishb_d;
    logic [DW-1:0] m_data_d;
    logic [15:0]   rd_frames_d;

    always_comb begin
        r_state_d   = r_state;
        rptr_d      = rptr;
        m_valid_d   = m_valid;
        m_data_d    = m_data;
        m_last_d    = m_last;
        finishb_d   = 1'b0;
        rd_frames_d = rd_frames;
        unique case (r_state)
            R_IDLE: begin
                if (ram_readyb) r_state_d = R_ADDR;
            end
            R_ADDR: r_state_d = R_DATA;
            R_DATA: begin
                m_data_d  = ram_doutb;
                m_valid_d = 1'b1;
                m_last_d  = (rptr == LAST);
                r_state_d = R_HOLD;
            end
            R_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last) begin
                        finishb_d   = 1'b1;
                        rd_frames_d = rd_frames + 16'd1;
                        r_state_d   = R_FIN;
                    end else begin
                        rptr_d    = rptr + AW'(1);
                        r_state_d = R_ADDR;
                    end
                end
            end
            R_FIN: begin
                rptr_d    = '0;
                r_state_d = R_SETTLE;
            end
            R_SETTLE: r_state_d = R_IDLE;
            default:  r_state_d = R_IDLE;
        endcase
    end

    // ram_addrb follows the next pointer so the address is already on the
    // RAM port during R_ADDR, and ram_doutb is valid when R_DATA samples it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= R_IDLE;
            rptr        <= '0;
            ram_addrb   <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            ram_finishb <= 1'b0;
            rd_frames   <= '0;
        end else begin
            r_state     <= r_state_d;
            rptr        <= rptr_d;
            ram_addrb   <= rptr_d;
            m_valid     <= m_valid_d;
            m_data      <= m_data_d;
            m_last      <= m_last_d;
            ram_finishb <= finishb_d;
            rd_frames   <= rd_frames_d;
        end
    end
endmodule

// File: doc/pingpong_ctrl.md
# pingpong_ctrl

Single-clock sequencer for `PINGPONG_RAM`. Port A takes a producer word stream, writes fixed-length frames into the RAM, and pulses `finisha` to hand each frame over. Port B waits for a full bank, reads it out word by word to the SPI transmitter over a valid/ready interface, and pulses `finishb` to release the bank. Both RAM ports are clocked by the same `clk` and reset by the same `rst` as this block.

## Interface
- `DW`, 16, data width (matches RAM `dina`/`doutb`)
- `AW`, 7, RAM address width
- `FRAME_LEN`, 64, words per frame, 1..2^AW

- `clk`  in  1  system clock; also drives RAM `clka`/`clkb`
- `rst`  in  1  reset, asynchronous, active-high; also drives RAM `rsta`/`rstb`
- `s_valid`  in  1  producer word valid
- `s_data`  in  DW  producer word
- `s_ready`  out  1  controller accepts the word this cycle
- `ram_addra`  out  AW  RAM write address
- `ram_wea`  out  1  RAM write enable
- `ram_dina`  out  DW  RAM write data
- `ram_finisha`  out  1  one-cycle pulse: write bank complete
- `ram_readya`  in  1  RAM has a free write bank
- `ram_addrb`  out  AW  RAM read address
- `ram_finishb`  out  1  one-cycle pulse: read bank consumed
- `ram_doutb`  in  DW  RAM read data, valid 1 cycle after `ram_addrb`
- `ram_readyb`  in  1  RAM has a full read bank
- `m_valid`  out  1  word to SPI valid
- `m_data`  out  DW  word to SPI
- `m_last`  out  1  qualifies the final word of a frame
- `m_ready`  in  1  SPI accepts the word
- `wr_frames`  out  16  frames committed (finisha count), wraps
- `rd_frames`  out  16  frames released (finishb count), wraps

## Operation
- All outputs are registered. Reset value is 0 for every output. Both FSMs reset to IDLE and both pointers to 0.
- Write FSM:
  - W_IDLE: `s_ready`=0. When `ram_readya`=1, go to W_FILL.
  - W_FILL: `s_ready`=1. Each accept (`s_valid & s_ready`) at edge t drives `ram_wea`=1, `ram_addra`=wptr and `ram_dina`=s_data during cycle t+1, then increments wptr. An accept at wptr==FRAME_LEN-1 clears `s_ready` and goes to W_FIN.
  - W_FIN: waits for the last write to retire, then asserts `ram_finisha` for exactly 1 cycle, increments `wr_frames`, resets wptr to 0, and goes to W_SETTLE.
  - W_SETTLE: ignores `ram_readya` for 1 cycle while the RAM swaps banks, then goes to W_IDLE.
- Read FSM:
  - R_IDLE: when `ram_readyb`=1, go to R_ADDR.
  - R_ADDR: drives `ram_addrb`=rptr, then goes to R_DATA.
  - R_DATA: captures `ram_doutb` into `m_data`, sets `m_valid`=1 and `m_last`=(rptr==FRAME_LEN-1), then goes to R_HOLD.
  - R_HOLD: holds `m_data`/`m_valid`/`m_last` stable until `m_ready`. On the handshake, `m_valid` drops.
    - Last word: go to R_FIN.
    - Otherwise: rptr+1, go to R_ADDR.
  - R_FIN: asserts `ram_finishb` for 1 cycle, increments `rd_frames`, resets rptr, and goes to R_SETTLE.
  - R_SETTLE: 1 cycle, then R_IDLE.
- The two FSMs are independent. Writing and reading proceed concurrently on opposite banks.
- Pointers are AW bits and never exceed FRAME_LEN-1; no wrap occurs inside a frame. Both frame counters wrap modulo 2^16.

## Timing
- Write side: one word per cycle sustained within a frame. Gap between frames is 3 cycles minimum (W_FIN, W_SETTLE, W_IDLE), longer if `ram_readya`=0.
- Write latency: accept of word k to `ram_wea` is 1 cycle. Last accept to `ram_finisha` is 2 cycles.
- Read side:
  - `ram_readyb` rise to first `m_valid` is 3 cycles (R_IDLE→R_ADDR→R_DATA→visible).
  - With `m_ready` held high, one word every 3 cycles.
  - `m_last` handshake to `ram_finishb` is 1 cycle.
- `m_valid` never drops without a handshake. `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Both RAM banks full (`ram_readya`=0): `s_ready` stays 0, so producer back-pressure is the only flow control. No data is dropped and no error is raised.
- A pulse of `ram_finisha` and `ram_finishb` in the same cycle is legal; the RAM resolves it.
- `rst` mid-frame: the partial write frame is abandoned with no `finisha`. The partial read frame is abandoned with no `finishb`. Outputs go to 0 asynchronously, and the RAM is reset by the same `rst`.

## Test plan
- Reset, then stream words 0..63 with `s_valid`=1 and `m_ready`=1. Required: `ram_wea` high for 64 consecutive cycles with `ram_addra` 0..63, one `ram_finisha` pulse 2 cycles after the last accept, `wr_frames`=1, and the SPI side receives 0..63 in order with `m_last` only on 63.
- 32 back-to-back frames with a 16-cycle idle gap between them, `dina`=i&0xFF. Required: `wr_frames`=`rd_frames`=32 and every frame read equals its write.
- `m_ready` held 0 while the producer keeps sending. Required: after 2 frames, `ram_readya`=0 and `s_ready` stays 0. Releasing `m_ready` resumes the flow with no lost or duplicated words.
- Random `m_ready` toggling. Required: `m_data` is stable while `m_valid & ~m_ready`, and `m_valid` never falls without a handshake.
- Assert `rst` at word 30 of a frame. Required: all outputs are 0 within the same cycle, with no `finisha`/`finishb`. After release, a fresh frame written from address 0 reads back correctly.
- Run with `FRAME_LEN`=1. Required: `finisha` follows every accept, and every `m_valid` carries `m_last`=1.
